adc_burst_sequencer: RTL and testbench

Multi-channel acquisition sequencer for the ultrasonic ranging front end. It fires one transmitter burst and opens a fixed receive window. On every sample tick inside that window, it walks the enabled ADC channels in ascending order, driving each channel's SPI master through an enable/finish handshake. Each result is written into the shared output FIFO as a channel-tagged word. It sits between the per-channel SPI master instances and the FIFO that feeds the MBED link, and replaces the single-channel free-running sampling logic.

---
 rtl/adc_burst_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_adc_burst_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_burst_sequencer.sv
// adc_burst_sequencer
// Fires one gated transmitter burst and opens a fixed receive window. On each
// sample tick inside the window it walks the enabled ADC channels in ascending
// order, handshaking with each channel's SPI master (spi_en level / spi_fin
// pulse). It then writes every result to the output FIFO as a {channel, data} word.
//
// Ports:
//   CLK_40       in   system clock (40 MHz)
//   rst          in   synchronous active-high reset
//   on           in   acquisition enable; a rising edge arms one window, low aborts
//   ch_mask      in   per-channel enable, latched at window start
//   spi_fin      in   per-channel one-cycle finish pulse from the SPI masters
//   spi_data     in   per-channel SPI results, channel i at [i*DW +: DW]
//   fifo_full    in   output FIFO full
//   spi_en       out  one-hot (or zero) level enable to the SPI masters
//   fifo_wr      out  one-cycle FIFO write strobe
//   fifo_din     out  {channel tag, data}; zero when not writing
//   tx_out       out  transmitter drive, gated to the start of the window
//   busy         out  window in progress
//   done         out  one-cycle pulse on normal window completion
//   overrun      out  sticky: a tick or a sample was lost this window
//   sample_count out  ticks counted this window (saturating)
module adc_burst_sequencer #(
  parameter int NCH        = 5,
  parameter int DW         = 16,
  parameter int TAGW       = 3,
  parameter int SAMPLE_DIV = 128,
  parameter int TX_HALF    = 512,
  parameter int TX_CYCLES  = 32,
  parameter int WINDOW     = 588800
) (
  input  logic                 CLK_40,
  input  logic                 rst,
  input  logic                 on,
  input  logic [NCH-1:0]       ch_mask,
  input  logic [NCH-1:0]       spi_fin,
  input  logic [NCH*DW-1:0]    spi_data,
  input  logic                 fifo_full,
  output logic [NCH-1:0]       spi_en,
  output logic                 fifo_wr,
  output logic [TAGW+DW-1:0]   fifo_din,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun,
  output logic [15:0]          sample_count
);

  localparam int WCW = $clog2(WINDOW + 1);
  localparam int DVW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TXW = (TX_HALF > 1) ? $clog2(TX_HALF) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_TICK, S_CONVERT, S_WRITE, S_DONE} state_t;

  // Lowest enabled channel at or above 'from'; MSB of the result is 'found'.
  function automatic logic [TAGW:0] find_ch(input logic [NCH-1:0] mask, input int from);
    logic [TAGW:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) r = {1'b1, TAGW'(i)};
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t              state, state_n;
  logic                on_q, on_qq, rise;
  logic [NCH-1:0]      mask_q;
  logic [TAGW-1:0]     ch_q;
  logic [DW-1:0]       data_q, data_cur;
  logic [NCH-1:0]      sel_oh;
  logic                fin_cur;
  logic [TAGW:0]       first, nextc;
  logic [WCW-1:0]      win_cnt;
  logic [DVW-1:0]      div_cnt;
  logic                win_end, tick;
  logic [TXW-1:0]      tx_cnt;
  logic                tx_sq;
  logic                start, ld_first, ld_next, cap, inc_cnt, set_ovr;

  assign rise    = on_q & ~on_qq;
  assign win_end = (win_cnt == WCW'(WINDOW));
  // Window end wins over a coincident tick.
  assign tick    = (div_cnt == '0) && (win_cnt != '0) && !win_end;
  assign first   = find_ch(mask_q, 0);
  assign nextc   = find_ch(mask_q, int'(ch_q) + 1);

  always_comb begin
    sel_oh   = '0;
    data_cur = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_q == TAGW'(i)) begin
        sel_oh[i] = 1'b1;
        data_cur  = spi_data[i*DW +: DW];
      end
    end
  end

  assign fin_cur = |(spi_fin & sel_oh);

  // Stage p0: control FSM
  always_ff @(posedge CLK_40) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Every action is gated by on_q so an abort takes effect at once.
  always_comb begin
    state_n  = state;
    start    = 1'b0;
    ld_first = 1'b0;
    ld_next  = 1'b0;
    cap      = 1'b0;
    inc_cnt  = 1'b0;
    set_ovr  = 1'b0;
    spi_en   = '0;
    fifo_wr  = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) begin
          start   = 1'b1;
          state_n = S_WAIT_TICK;
        end
      end
      S_WAIT_TICK: begin
        if (!on_q) state_n = S_IDLE;
        else if (win_end) state_n = S_DONE;
        else if (tick) begin
          inc_cnt = 1'b1;
          if (first[TAGW]) begin
            ld_first = 1'b1;
            state_n  = S_CONVERT;
          end
        end
      end
      S_CONVERT: begin
        if (!on_q) state_n = S_IDLE;
        else begin
          spi_en = sel_oh;
          if (tick) set_ovr = 1'b1;
          if (fin_cur) begin
            cap     = 1'b1;
            state_n = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (!on_q) state_n = S_IDLE;
        else begin
          fifo_wr = !fifo_full;
          if (fifo_full || tick) set_ovr = 1'b1;
          if (nextc[TAGW]) begin
            ld_next = 1'b1;
            state_n = S_CONVERT;
          end else if (win_end) state_n = S_DONE;
          else state_n = S_WAIT_TICK;
        end
      end
      S_DONE: begin
        done    = on_q;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_40) begin
    if (rst) begin
      on_q         <= 1'b0;
      on_qq        <= 1'b0;
      mask_q       <= '0;
      ch_q         <= '0;
      win_cnt      <= '0;
      div_cnt      <= '0;
      tx_cnt       <= '0;
      tx_sq        <= 1'b0;
      overrun      <= 1'b0;
      sample_count <= '0;
    end else begin
      on_q  <= on;
      on_qq <= on_q;
      if (tx_cnt == TXW'(TX_HALF - 1)) begin
        tx_cnt <= '0;
        tx_sq  <= ~tx_sq;
      end else begin
        tx_cnt <= tx_cnt + TXW'(1);
      end
      if (start) begin
        mask_q       <= ch_mask;
        win_cnt      <= '0;
        div_cnt      <= '0;
        overrun      <= 1'b0;
        sample_count <= '0;
      end else begin
        if (busy && !win_end) win_cnt <= win_cnt + WCW'(1);
        if (busy) div_cnt <= (div_cnt == DVW'(SAMPLE_DIV - 1)) ? '0 : div_cnt + DVW'(1);
        if (set_ovr) overrun <= 1'b1;
        if (inc_cnt) sample_count <= sat_inc16(sample_count);
      end
      if (ld_first)     ch_q <= first[TAGW-1:0];
      else if (ld_next) ch_q <= nextc[TAGW-1:0];
    end
  end

  // Stage p1: captured sample
  always_ff @(posedge CLK_40) begin
    if (cap) data_q <= data_cur;
  end

  assign busy     = (state == S_WAIT_TICK) || (state == S_CONVERT) || (state == S_WRITE);
  assign fifo_din = fifo_wr ? {ch_q, data_q} : '0;
  assign tx_out   = tx_sq && busy && on_q && (win_cnt < WCW'(TX_CYCLES));

endmodule

// File: tb/tb_adc_burst_sequencer.sv
// Testbench for adc_burst_sequencer: a responsive SPI master model, a
// round-based reference model of the sequencer and a per-cycle comparison,
// plus directed scenarios with literal expectations.
module tb_adc_burst_sequencer;
  localparam int NCH = 5, DW = 16, TAGW = 3, SAMPLE_DIV = 128;
  localparam int TX_HALF = 16, TX_CYCLES = 32, WINDOW = 2000;

  logic CLK_40 = 1'b0;
  logic rst = 1'b1, on = 1'b0, fifo_full = 1'b0;
  logic [NCH-1:0] ch_mask = '0, spi_fin = '0;
  logic [NCH*DW-1:0] spi_data = '0;
  logic [NCH-1:0] spi_en;
  logic fifo_wr, tx_out, busy, done, overrun;
  logic [TAGW+DW-1:0] fifo_din;
  logic [15:0] sample_count;

  adc_burst_sequencer #(.NCH(NCH), .DW(DW), .TAGW(TAGW), .SAMPLE_DIV(SAMPLE_DIV),
    .TX_HALF(TX_HALF), .TX_CYCLES(TX_CYCLES), .WINDOW(WINDOW)) dut (
    .CLK_40(CLK_40), .rst(rst), .on(on), .ch_mask(ch_mask), .spi_fin(spi_fin),
    .spi_data(spi_data), .fifo_full(fifo_full), .spi_en(spi_en), .fifo_wr(fifo_wr),
    .fifo_din(fifo_din), .tx_out(tx_out), .busy(busy), .done(done), .overrun(overrun),
    .sample_count(sample_count));

  always #5 CLK_40 = ~CLK_40;

  int checks = 0, errors = 0;
  int fin_dly = 20, ff_mode = 0;
  int wr_cnt = 0, done_cnt = 0, tx_hi = 0, en_seen = 0, overlap_cnt = 0, tag_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: window age, per-round channel queue, current channel.
  int  m_win = -1, m_cur = -1, m_cnt = 0, m_n = 0;
  bit  m_wrpend = 0, m_done = 0, m_ovr = 0, m_on1 = 0, m_on2 = 0, m_valid = 0;
  bit  on_now, rise, was_done, tk, wend;
  logic [NCH-1:0] m_mask = '0;
  logic [DW-1:0]  m_data = '0;
  int  m_q[$];

  always @(posedge CLK_40) begin
    if (rst) begin
      m_valid = 1; m_win = -1; m_cur = -1; m_wrpend = 0; m_done = 0; m_ovr = 0;
      m_cnt = 0; m_on1 = 0; m_on2 = 0; m_n = 0; m_q.delete(); m_mask = '0;
    end else begin
      on_now = m_on1; rise = m_on1 && !m_on2; was_done = m_done; m_done = 0; m_n++;
      if (m_win < 0) begin
        if (!was_done && rise) begin
          m_win = 0; m_mask = ch_mask; m_cnt = 0; m_ovr = 0; m_cur = -1; m_wrpend = 0;
          m_q.delete();
        end
      end else if (!on_now) begin
        m_win = -1; m_cur = -1; m_wrpend = 0; m_q.delete();
      end else begin
        tk   = (m_win > 0) && (m_win % SAMPLE_DIV == 0) && (m_win < WINDOW);
        wend = (m_win >= WINDOW);
        if (m_cur < 0) begin
          if (wend) begin m_done = 1; m_win = -1; end
          else if (tk) begin
            if (m_cnt < 65535) m_cnt++;
            for (int i = 0; i < NCH; i++) if (m_mask[i]) m_q.push_back(i);
            if (m_q.size() > 0) m_cur = m_q.pop_front();
          end
        end else begin
          if (tk) m_ovr = 1;
          if (!m_wrpend) begin
            if (spi_fin[m_cur]) begin m_data = spi_data[m_cur*DW +: DW]; m_wrpend = 1; end
          end else begin
            if (fifo_full) m_ovr = 1;
            m_wrpend = 0;
            if (m_q.size() > 0) m_cur = m_q.pop_front();
            else begin
              m_cur = -1;
              if (wend) begin m_done = 1; m_win = -1; end
            end
          end
        end
        if (m_win >= 0) m_win++;
      end
      m_on2 = m_on1; m_on1 = on;
    end
  end

  // Per-cycle comparison against the model.
  logic [NCH-1:0] e_en;
  logic e_wr, e_tx, e_done;
  logic [TAGW+DW-1:0] e_din;

  always @(negedge CLK_40) begin
    if (m_valid) begin
      e_en   = (m_win >= 0 && m_cur >= 0 && !m_wrpend && m_on1) ? NCH'(1 << m_cur) : '0;
      e_wr   = (m_win >= 0) && (m_cur >= 0) && m_wrpend && m_on1 && !fifo_full;
      e_din  = e_wr ? {TAGW'(m_cur), m_data} : '0;
      e_tx   = (m_win >= 0) && m_on1 && (m_win < TX_CYCLES) && ((m_n / TX_HALF) % 2 == 1);
      e_done = m_done && m_on1;
      check("busy", busy, m_win >= 0);
      check("spi_en", spi_en, e_en);
      check("fifo_wr", fifo_wr, e_wr);
      check("fifo_din", fifo_din, e_din);
      check("tx_out", tx_out, e_tx);
      check("done", done, e_done);
      check("overrun", overrun, m_ovr);
      check("sample_count", sample_count, m_cnt);
      if (fifo_wr) begin
        if (fifo_din[DW +: TAGW] != TAGW'((wr_cnt % 3) * 2)) tag_bad++;
        wr_cnt++;
      end
      if (done) done_cnt++;
      if (tx_out) tx_hi++;
      if (spi_en != '0) en_seen++;
      if (!$onehot0(spi_en)) overlap_cnt++;
    end
  end

  // SPI masters (fin fin_dly cycles into enable, stray fins on idle channels) and FIFO.
  int fcnt[NCH];
  initial begin
    for (int i = 0; i < NCH; i++) fcnt[i] = 0;
    forever begin
      @(posedge CLK_40); #1;
      for (int i = 0; i < NCH; i++) begin
        if (spi_en[i]) fcnt[i]++; else fcnt[i] = 0;
        if (spi_en[i] && fcnt[i] == fin_dly) begin
          spi_fin[i] = 1'b1;
          spi_data[i*DW +: DW] = DW'($urandom);
        end else begin
          spi_fin[i] = !spi_en[i] && ($urandom_range(0, 15) == 0);
        end
      end
      case (ff_mode)
        1:       fifo_full = (m_cnt == 3);
        2:       fifo_full = ($urandom_range(0, 5) == 0);
        default: fifo_full = 1'b0;
      endcase
    end
  end

  task automatic step();
    @(posedge CLK_40); #1;
  endtask

  task automatic clr_mon();
    wr_cnt = 0; done_cnt = 0; tx_hi = 0; en_seen = 0; overlap_cnt = 0; tag_bad = 0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 2600) begin step(); k++; end
    check(nm, k < 2600, 1'b1);
    repeat (3) step();
  endtask

  task automatic stop_window();
    on = 1'b0; ff_mode = 0;
    repeat (4) step();
  endtask

  task automatic wait_conv(input int rounds, input string nm);
    int k;
    k = 0;
    while (!(m_cnt >= rounds && spi_en != '0) && k < 3000) begin step(); k++; end
    check(nm, k < 3000, 1'b1);
  endtask

  int saved_wr;

  initial begin
    rst = 1'b1; on = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge CLK_40);
    check("rst_busy", busy, 0); check("rst_cnt", sample_count, 0);
    check("rst_spi_en", spi_en, 0); check("rst_ovr", overrun, 0);

    // Three of five channels, fast SPI.
    clr_mon(); fin_dly = 20; ch_mask = 5'b10101; on = 1'b1;
    step(); @(negedge CLK_40); check("A_busy_lat1", busy, 0);
    step(); @(negedge CLK_40); check("A_busy_lat2", busy, 1);
    wait_done("A_timeout");
    check("A_writes", wr_cnt, 45); check("A_tags", tag_bad, 0);
    check("A_count", sample_count, 15); check("A_done", done_cnt, 1);
    check("A_ovr", overrun, 0);
    stop_window();

    // Empty mask: ticks counted, no conversions, transmitter burst only.
    clr_mon(); ch_mask = 5'b00000; on = 1'b1;
    wait_done("B_timeout");
    check("B_writes", wr_cnt, 0); check("B_en", en_seen, 0);
    check("B_count", sample_count, 15); check("B_done", done_cnt, 1);
    check("B_tx_hi", tx_hi, 16);
    stop_window();

    // FIFO full for all of round 3.
    clr_mon(); ch_mask = 5'b10101; ff_mode = 1; on = 1'b1;
    wait_done("C_timeout");
    check("C_writes", wr_cnt, 42); check("C_ovr", overrun, 1);
    check("C_count", sample_count, 15); check("C_done", done_cnt, 1);
    stop_window();

    // Slow SPI: rounds overrun the tick period.
    clr_mon(); ch_mask = 5'b01011; fin_dly = 60; on = 1'b1;
    wait_done("D_timeout");
    check("D_ovr", overrun, 1); check("D_overlap", overlap_cnt, 0);
    check("D_done", done_cnt, 1); check("D_some_writes", wr_cnt > 0, 1'b1);
    stop_window();

    // Abort mid-CONVERT, then restart.
    clr_mon(); ch_mask = 5'b01011; fin_dly = 60; on = 1'b1;
    wait_conv(3, "E_reach");
    on = 1'b0;
    step(); saved_wr = wr_cnt;
    @(negedge CLK_40); check("E_spi_en_off", spi_en, 0);
    repeat (6) step();
    @(negedge CLK_40);
    check("E_busy", busy, 0); check("E_writes_after", wr_cnt - saved_wr, 0);
    check("E_done", done_cnt, 0); check("E_ovr_held", overrun, 1);
    on = 1'b1; step(); step();
    @(negedge CLK_40);
    check("E_restart_busy", busy, 1); check("E_restart_ovr", overrun, 0);
    check("E_restart_cnt", sample_count, 0);
    stop_window();

    // Reset mid-window.
    clr_mon(); ch_mask = 5'b10101; fin_dly = 20; on = 1'b1;
    wait_conv(2, "F_reach");
    rst = 1'b1; on = 1'b0;
    step(); @(negedge CLK_40);
    check("F_spi_en", spi_en, 0); check("F_fifo_wr", fifo_wr, 0);
    check("F_fifo_din", fifo_din, 0); check("F_tx", tx_out, 0);
    check("F_busy", busy, 0); check("F_done", done, 0);
    check("F_ovr", overrun, 0); check("F_cnt", sample_count, 0);
    rst = 1'b0;
    repeat (3) step();

    // Randomized windows with random FIFO back-pressure.
    for (int r = 0; r < 4; r++) begin
      clr_mon(); ch_mask = NCH'($urandom); fin_dly = $urandom_range(3, 30);
      ff_mode = 2; on = 1'b1;
      wait_done("R_timeout");
      check("R_done", done_cnt, 1); check("R_overlap", overlap_cnt, 0);
      stop_window();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
